// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive/transmit types and constants
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } uart_rx_state_t;

    localparam int UART_OVS       = 16;
    localparam int UART_SMP_LO    = 7;
    localparam int UART_SMP_MID   = 8;
    localparam int UART_SMP_HI    = 9;
    localparam int UART_WLEN_BASE = 5;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one tick every div+1 clocks
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             term;

    // >= keeps the counter bounded if div shrinks while it is running
    assign term = (cnt_q >= div);
    assign tick = !clr && term;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || term) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampling UART receiver with one-entry holding register
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             app_clk,
    input  logic             reset_n,
    input  logic             rxd,
    input  logic [DIV_W-1:0] cfg_baud_div,
    input  logic [1:0]       cfg_wlen,
    input  logic             cfg_pen,
    input  logic             cfg_even,
    input  logic             cfg_stop2,
    output logic [7:0]       rx_data,
    output logic             rx_perr,
    output logic             rx_ferr,
    output logic             rx_break,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             rx_busy
);

    localparam logic [3:0] SMP_LO   = 4'(UART_SMP_LO);
    localparam logic [3:0] SMP_MID  = 4'(UART_SMP_MID);
    localparam logic [3:0] SMP_HI   = 4'(UART_SMP_HI);
    localparam logic [3:0] SMP_LAST = 4'(UART_OVS - 1);
    localparam logic [2:0] IDX_BASE = 3'(UART_WLEN_BASE - 1);

    logic           rxd_s1_q, rxs_q, rxs_prev_q;
    uart_rx_state_t state_q, state_d;
    logic [3:0]     s_q, s_d;
    logic [1:0]     smp_q, smp_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic           perr_q, perr_d;
    logic           ferr_q, ferr_d;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       wlen_q, wlen_d;
    logic             pen_q, pen_d;
    logic             even_q, even_d;
    logic             stop2_q, stop2_d;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_perr_q, rx_perr_d;
    logic       rx_ferr_q, rx_ferr_d;
    logic       rx_break_q, rx_break_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_overrun_q, rx_overrun_d;

    logic       tick, start_edge, bit_val, at_dec, at_end, last_data, complete;
    logic       frame_ferr;
    logic [2:0] last_idx;

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_baud_tick (
        .clk  (app_clk),
        .rst_n(reset_n),
        .clr  (state_q == ST_IDLE),
        .div  (div_q),
        .tick (tick)
    );

    assign start_edge = rxs_prev_q && !rxs_q;
    assign bit_val    = maj3(smp_q[0], smp_q[1], rxs_q);
    assign at_dec     = tick && (s_q == SMP_HI);
    assign at_end     = tick && (s_q == SMP_LAST);
    assign last_idx   = {1'b0, wlen_q} + IDX_BASE;
    assign last_data  = (bit_cnt_q == last_idx);
    assign complete   = at_dec && (((state_q == ST_STOP1) && !stop2_q) || (state_q == ST_STOP2));
    assign frame_ferr = ferr_q | ~bit_val;

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_s1_q     <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            s_q          <= '0;
            smp_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            div_q        <= '0;
            wlen_q       <= '0;
            pen_q        <= 1'b0;
            even_q       <= 1'b0;
            stop2_q      <= 1'b0;
            rx_data_q    <= '0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_break_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rxd_s1_q     <= rxd;
            rxs_q        <= rxd_s1_q;
            rxs_prev_q   <= rxs_q;
            state_q      <= state_d;
            s_q          <= s_d;
            smp_q        <= smp_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            div_q        <= div_d;
            wlen_q       <= wlen_d;
            pen_q        <= pen_d;
            even_q       <= even_d;
            stop2_q      <= stop2_d;
            rx_data_q    <= rx_data_d;
            rx_perr_q    <= rx_perr_d;
            rx_ferr_q    <= rx_ferr_d;
            rx_break_q   <= rx_break_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_edge) state_d = ST_START;
            ST_START: begin
                if (at_dec && bit_val) state_d = ST_IDLE;
                else if (at_end)       state_d = ST_DATA;
            end
            ST_DATA:   if (at_end && last_data) state_d = pen_q ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (at_end) state_d = ST_STOP1;
            ST_STOP1: begin
                if (at_dec && !stop2_q) state_d = ST_IDLE;
                else if (at_end)        state_d = ST_STOP2;
            end
            ST_STOP2:  if (at_dec) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (state_q != ST_IDLE);
    end

    always_comb begin
        s_d       = s_q;
        smp_d     = smp_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        div_d     = div_q;
        wlen_d    = wlen_q;
        pen_d     = pen_q;
        even_d    = even_q;
        stop2_d   = stop2_q;
        if (state_q == ST_IDLE) begin
            bit_cnt_d = '0;
            // frame format is frozen here so mid-frame config writes cannot corrupt it
            if (start_edge) begin
                div_d   = cfg_baud_div;
                wlen_d  = cfg_wlen;
                pen_d   = cfg_pen;
                even_d  = cfg_even;
                stop2_d = cfg_stop2;
                shift_d = '0;
                par_d   = 1'b0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
            end
        end else if (tick) begin
            s_d = s_q + 4'd1;
            if (s_q == SMP_LO)  smp_d[0] = rxs_q;
            if (s_q == SMP_MID) smp_d[1] = rxs_q;
            if (s_q == SMP_HI) begin
                case (state_q)
                    ST_DATA: begin
                        shift_d[bit_cnt_q] = bit_val;
                        par_d              = par_q ^ bit_val;
                    end
                    ST_PARITY:          perr_d = (bit_val != (par_q ^ ~even_q));
                    ST_STOP1, ST_STOP2: ferr_d = frame_ferr;
                    default:            ;
                endcase
            end
            if ((state_q == ST_DATA) && (s_q == SMP_LAST) && !last_data) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
        if (state_d == ST_IDLE) begin
            s_d = '0;
        end
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_perr_d    = rx_perr_q;
        rx_ferr_d    = rx_ferr_q;
        rx_break_d   = rx_break_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = 1'b0;
        if (complete) begin
            // a same-cycle accept frees the slot for the new character
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_perr_d  = perr_q;
                rx_ferr_d  = frame_ferr;
                rx_break_d = frame_ferr && (shift_q == 8'h00);
                rx_valid_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_perr    = rx_perr_q;
    assign rx_ferr    = rx_ferr_q;
    assign rx_break   = rx_break_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

- Synthesizable UART receive stage. It sits directly downstream of the serial line that the testbench UART agent drives through its `txd`.
- Takes the asynchronous `rxd` input and oversamples it 16x from a programmable baud divider.
- Deframes 5–8 data bits with optional parity and 1 or 2 stop bits.
- Presents each character through a one-entry valid/ready holding register, with per-character error flags, toward the UART register/FIFO logic.

## Interface
Parameters:
- `DIV_W`, default 16: width of the baud divisor.

Ports:
- `app_clk`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `rxd`, in, 1: serial input, asynchronous; idles high.
- `cfg_baud_div`, in, DIV_W: oversample tick every `cfg_baud_div+1` clocks. One bit lasts `16*(cfg_baud_div+1)` clocks.
- `cfg_wlen`, in, 2: data bits = `cfg_wlen+5`.
- `cfg_pen`, in, 1: parity enable.
- `cfg_even`, in, 1: 1 = even parity, 0 = odd parity.
- `cfg_stop2`, in, 1: 1 = two stop bits.
- `rx_data`, out, 8: received character, LSB first. Unused upper bits are 0.
- `rx_perr`, out, 1: parity error for the held character.
- `rx_ferr`, out, 1: framing error (a stop sample was 0) for the held character.
- `rx_break`, out, 1: held character has all data bits 0 and ferr set.
- `rx_valid`, out, 1: holding register full.
- `rx_ready`, in, 1: consumer accepts the character on `rx_valid && rx_ready`.
- `rx_overrun`, out, 1: one-cycle pulse when a completed character is dropped.
- `rx_busy`, out, 1: FSM not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rxs`.
- The tick counter runs 0..`cfg_baud_div` and issues a tick at terminal count. It is held at 0 in IDLE, so a start edge restarts phase.
- The sample counter `s` runs 0..15 per bit. Bit value = majority of `rxs` at ticks s=7, 8, 9; the decision is made at s=9.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE → START on a `rxs` falling edge. Config is latched at this point; config changes mid-frame take effect on the next frame.
  - START: if the decided value is 1, it is a glitch. Return to IDLE with no output.
  - START → DATA at s=15.
  - DATA: shift in data bits LSB-first, accumulating the parity XOR. After the last bit at s=15, go to PARITY if parity is enabled, else STOP1.
  - PARITY: flag an error if the received bit ≠ expected bit. Expected = XOR of data bits for even parity, and its inverse for odd parity. → STOP1 at s=15.
  - STOP1: at s=9, ferr |= !bit. Then go to STOP2 (after s=15) if `cfg_stop2` is set; otherwise complete and go to IDLE immediately at s=9.
  - STOP2: at s=9, ferr |= !bit, complete, go to IDLE.
- Completion: if `rx_valid`=0, or `rx_ready`=1 in the same cycle, load the holding register and set `rx_valid`. Otherwise the new character is discarded and `rx_overrun` pulses.
- Accept: `rx_valid && rx_ready` with no completion in that cycle clears `rx_valid`. The data and flag outputs keep their last value.

## Timing
- Reset values:
  - `rx_data` = 0; `rx_perr`, `rx_ferr`, `rx_break`, `rx_valid`, `rx_overrun`, `rx_busy` = 0.
  - FSM in IDLE; all counters 0.
- Reset asserted mid-frame aborts immediately. The partial character is lost and no flags are raised.
- Latency: `rx_valid` rises one clock after the completion tick.
  - With div=0, the raw `rxd` start edge lands in IDLE 2 clocks later (synchronizer), plus one clock for edge detection.
  - 8N1, div=0: start edge to completion = 9*16+10 ticks.
- `rx_overrun` is exactly 1 clock wide and coincident with the cycle `rx_valid` would have loaded.
- Back-to-back frames: a new start edge is recognised from the first IDLE cycle after completion. This tolerates a stop bit shortened by up to 6/16.
- A break (continuous low) gives one character with ferr and break set. No further start is detected until `rxs` returns high.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t`
  - `UART_OVS` = 16
  - `UART_SMP_LO/MID/HI` = 7/8/9
  - `UART_WLEN_BASE` = 5
- One sub-module, `uart_baud_tick`: divisor counter with a sync clear, output `tick`. It is reusable by the future transmit stage.
- The synchronizer is inline in `uart_rx_core`.

## Test plan
- div=0, 8N1, byte 0xA5 with `rx_ready`=1 → `rx_valid` pulses once; `rx_data`=0xA5; perr/ferr=0.
- div=3, 7E2, byte 0x35, then the same frame with the parity bit inverted → first: `rx_data`=0x35, perr=0. Second: perr=1.
- div=0, 8N1, stop bit driven 0, data 0x00 → ferr=1, break=1, `rx_data`=0x00. After `rxd` returns high, the next 0x5A frame is received clean.
- `rx_ready`=0, two frames 0x11 then 0x22 → `rx_data` stays 0x11 and `rx_overrun` pulses once. Then raise ready → `rx_valid` drops the next clock.
- 5-clock low glitch on `rxd`, div=0 → no `rx_valid`; `rx_busy` returns to 0 within 16 clocks.
- Assert `reset_n` low mid-DATA of a 0xC3 frame → all outputs 0. The next full 0x3C frame is received correctly.
